duty_ctrl: RTL

DUTY_CTRL -- requirements
Module: duty_ctrl

---
 rtl/duty_ctrl_pkg.sv | 14 +
 rtl/btn_debounce.sv | 65 ++++++
 rtl/duty_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/duty_ctrl_pkg.sv
// Shared types and defaults for the duty_ctrl push-button duty-cycle controller.
package duty_ctrl_pkg;

  localparam int DUTY_W            = 4;
  localparam int DUTY_INIT_DEFAULT = 5;
  localparam int DUTY_MAX_DEFAULT  = 10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_INC = 2'd1,
    HOLD_DEC = 2'd2
  } hold_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, tick-sampled agreement counter,
// stable level and press strobe. held_o exists only with DUTY_CTRL_AUTO_REPEAT_EN.
module btn_debounce
  import duty_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  input  logic tick_i,
  output logic stable_o,
  output logic press_o
`ifdef DUTY_CTRL_AUTO_REPEAT_EN
  ,
  output logic held_o
`endif
);

  localparam int CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    press_o  = 1'b0;
    if (tick_i) begin
      if (sync2_q == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == CW'(DEBOUNCE_CNT - 1)) begin
        // Level accepted; only a rising acceptance produces a press.
        stable_d = sync2_q;
        cnt_d    = '0;
        press_o  = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

`ifdef DUTY_CTRL_AUTO_REPEAT_EN
  // Still held means the synchronized input has not yet started a release.
  assign held_o = stable_q & sync2_q;
`endif

endmodule

// File: rtl/duty_ctrl.sv
// Duty-cycle step controller driven by two debounced push-buttons.
// Optional auto-repeat while a button is held: define DUTY_CTRL_AUTO_REPEAT_EN.
module duty_ctrl
  import duty_ctrl_pkg::*;
#(
  parameter int CLK_DIV      = 25000000,
  parameter int DEBOUNCE_CNT = 3,
  parameter int DUTY_INIT    = DUTY_INIT_DEFAULT,
  parameter int DUTY_MAX     = DUTY_MAX_DEFAULT,
  parameter int REPEAT_DELAY = 4,
  parameter int REPEAT_RATE  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              increase_duty,
  input  logic              decrease_duty,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              duty_update,
  output logic              at_max,
  output logic              at_min
);

  localparam int                DIV_W = $clog2(CLK_DIV);
  localparam logic [DUTY_W-1:0] DMAX  = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] DINIT = DUTY_W'(DUTY_INIT);

  logic [DIV_W-1:0]  div_q, div_d;
  logic              tick;
  logic              inc_stable, dec_stable, inc_ev, dec_ev;
  logic              inc_step, dec_step;
  hold_state_e       state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              upd_q, upd_d;
  logic              at_max_q, at_max_d, at_min_q, at_min_d;

  always_comb begin
    tick  = (div_q == DIV_W'(CLK_DIV - 1));
    div_d = tick ? '0 : div_q + DIV_W'(1);
  end

`ifdef DUTY_CTRL_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic             inc_held, dec_held, rep_held, rep_ev;
  logic [RPT_W-1:0] rep_cnt_q, rep_cnt_d, rep_lim;
  logic             rep_phase_q, rep_phase_d;

  btn_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_inc_db (
    .clk_i(clk), .rst_ni(rst_n), .btn_i(increase_duty), .tick_i(tick),
    .stable_o(inc_stable), .press_o(inc_ev), .held_o(inc_held)
  );

  btn_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_dec_db (
    .clk_i(clk), .rst_ni(rst_n), .btn_i(decrease_duty), .tick_i(tick),
    .stable_o(dec_stable), .press_o(dec_ev), .held_o(dec_held)
  );

  // First repeat after REPEAT_DELAY held ticks, then every REPEAT_RATE ticks.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_phase_d = rep_phase_q;
    rep_ev      = 1'b0;
    rep_lim     = rep_phase_q ? RPT_W'(REPEAT_RATE - 1) : RPT_W'(REPEAT_DELAY - 1);
    case (state_q)
      HOLD_INC: rep_held = inc_held;
      HOLD_DEC: rep_held = dec_held;
      default:  rep_held = 1'b0;
    endcase
    if (state_q == IDLE) begin
      rep_cnt_d   = '0;
      rep_phase_d = 1'b0;
    end else if (tick && rep_held) begin
      if (rep_cnt_q == rep_lim) begin
        rep_ev      = 1'b1;
        rep_cnt_d   = '0;
        rep_phase_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + RPT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_phase_q <= rep_phase_d;
    end
  end
`else
  btn_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_inc_db (
    .clk_i(clk), .rst_ni(rst_n), .btn_i(increase_duty), .tick_i(tick),
    .stable_o(inc_stable), .press_o(inc_ev)
  );

  btn_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_dec_db (
    .clk_i(clk), .rst_ni(rst_n), .btn_i(decrease_duty), .tick_i(tick),
    .stable_o(dec_stable), .press_o(dec_ev)
  );
`endif

  // Simultaneous presses cancel; a hold locks out the opposite button.
  always_comb begin
    state_d  = state_q;
    inc_step = 1'b0;
    dec_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (inc_ev && !dec_ev) begin
          inc_step = 1'b1;
          if (!dec_stable) state_d = HOLD_INC;
        end else if (dec_ev && !inc_ev) begin
          dec_step = 1'b1;
          if (!inc_stable) state_d = HOLD_DEC;
        end
      end
      HOLD_INC: begin
        if (!inc_stable) state_d = IDLE;
`ifdef DUTY_CTRL_AUTO_REPEAT_EN
        else inc_step = rep_ev;
`endif
      end
      HOLD_DEC: begin
        if (!dec_stable) state_d = IDLE;
`ifdef DUTY_CTRL_AUTO_REPEAT_EN
        else dec_step = rep_ev;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    duty_d = duty_q;
    upd_d  = 1'b0;
    if (inc_step && (duty_q < DMAX)) begin
      duty_d = duty_q + DUTY_W'(1);
      upd_d  = 1'b1;
    end else if (dec_step && (duty_q != '0)) begin
      duty_d = duty_q - DUTY_W'(1);
      upd_d  = 1'b1;
    end
    at_max_d = (duty_d == DMAX);
    at_min_d = (duty_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      state_q  <= IDLE;
      duty_q   <= DINIT;
      upd_q    <= 1'b0;
      at_max_q <= (DINIT == DMAX);
      at_min_q <= (DINIT == '0);
    end else begin
      div_q    <= div_d;
      state_q  <= state_d;
      duty_q   <= duty_d;
      upd_q    <= upd_d;
      at_max_q <= at_max_d;
      at_min_q <= at_min_d;
    end
  end

  assign duty_cycle  = duty_q;
  assign duty_update = upd_q;
  assign at_max      = at_max_q;
  assign at_min      = at_min_q;

endmodule
